// File: rtl/cnt_run_sched.sv
// Round-robin scheduler sharing one eight_bit_cnt between NREQ requesters.
// Issues trig, tracks the en window, returns the 9-bit count with done.
module cnt_run_sched #(
   parameter int NREQ     = 4,
   parameter int TRIG_LEN = 100,
   parameter int TIMEOUT  = 1023,
   parameter int GAP      = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic [8:0]      result,
   output logic            err,
   output logic            busy,
   output logic            trig,
   input  logic            cnt_en,
   input  logic [8:0]      cnt_count
);

   localparam int PW  = $clog2(NREQ);
   localparam int TWA = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
   localparam int TWB = ($clog2(TRIG_LEN + 1) > TWA) ? $clog2(TRIG_LEN + 1) : TWA;
   localparam int TW  = ($clog2(GAP + 1) > TWB) ? $clog2(GAP + 1) : TWB;

   localparam logic [TW-1:0] T_TRIG = TW'(TRIG_LEN - 1);
   localparam logic [TW-1:0] T_OUT  = TW'(TIMEOUT);
   localparam logic [TW-1:0] T_GAP  = TW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [PW:0]   N_REQ  = (PW + 1)'(NREQ);
   localparam logic [PW-1:0] P_LAST = PW'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT, S_RUN, S_DONE, S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [8:0]        result_q, result_d;
   logic              err_q, err_d;
   logic              trig_q, trig_d;

   logic              found;
   logic [PW-1:0]     win;
   logic [PW-1:0]     win_nxt;
   logic [PW:0]       sum;

   // First set request at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr_q} + (PW + 1)'(i);
         if (sum >= N_REQ) sum = sum - N_REQ;
         if (!found && req[sum[PW-1:0]]) begin
            found = 1'b1;
            win   = sum[PW-1:0];
         end
      end
      win_nxt = (win == P_LAST) ? '0 : win + 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      result_d = result_q;
      err_d    = err_q;
      trig_d   = trig_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               trig_d     = 1'b1;
               timer_d    = '0;
               ptr_d      = win_nxt;
               state_d    = S_TRIG;
            end
         end
         S_TRIG: begin
            if (timer_q == T_TRIG) begin
               trig_d  = 1'b0;
               timer_d = '0;
               state_d = S_WAIT;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         S_WAIT: begin
            if (cnt_en) begin
               timer_d = '0;
               state_d = S_RUN;
            end else if (timer_q == T_OUT) begin
               state_d  = S_DONE;
               done_d   = gnt_q;
               result_d = cnt_count;
               err_d    = 1'b1;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         S_RUN: begin
            if (!cnt_en || timer_q == T_OUT) begin
               state_d  = S_DONE;
               done_d   = gnt_q;
               result_d = cnt_count;
               err_d    = cnt_en;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         S_DONE: begin
            gnt_d   = '0;
            timer_d = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (timer_q == T_GAP) state_d = S_IDLE;
            else timer_d = timer_q + T_ONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         ptr_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         trig_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
         trig_q   <= trig_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;
   assign trig   = trig_q;
   assign busy   = (state_q != S_IDLE);

endmodule
